// File: rtl/hog_pkg.sv
// Shared constants, typedefs and parameter checks for the HOG orientation-binning path.
package hog_pkg;

  localparam int  SCALE_FRAC = 12;
  localparam real PI         = 3.14159265358979323846;

  typedef logic [10:0] fold_t;
  typedef logic [3:0]  bin_t;

  function automatic int calc_range(input int angle_frac, input bit full_circle);
    real r;
    r = PI * (2.0 ** angle_frac);
    if (full_circle) r = r * 2.0;
    return $rtoi(r + 0.5);
  endfunction

  function automatic int calc_scale(input int num_bins, input bit full_circle);
    real range;
    range = full_circle ? 2.0 * PI : PI;
    return $rtoi((real'(num_bins) / range) * (2.0 ** SCALE_FRAC) + 0.5);
  endfunction

  function automatic bit params_ok(input int num_bins, input int bin_w);
    return (num_bins >= 2) && ((1 << bin_w) >= num_bins);
  endfunction

endpackage

// File: rtl/hog_bin_vote_if.sv
// Pixel-in / vote-out bundle between the gradient unit, the binning stage and the histogram accumulator.
interface hog_bin_vote_if #(
  parameter int ANGLE_W = 12,
  parameter int MAG_W   = 12,
  parameter int BIN_W   = 4,
  parameter int FRAC_W  = 8
);
  logic                      de;
  logic signed [ANGLE_W-1:0] angle;
  logic [MAG_W-1:0]          mag;
  logic                      deOut;
  logic [BIN_W-1:0]          bottomBin;
  logic [BIN_W-1:0]          topBin;
  logic [FRAC_W-1:0]         weightTop;
  logic [MAG_W-1:0]          magBottom;
  logic [MAG_W-1:0]          magTop;
  logic [ANGLE_W-2:0]        angleFold;

  modport master (output de, angle, mag,
                  input  deOut, bottomBin, topBin, weightTop, magBottom, magTop, angleFold);
  modport slave  (input  de, angle, mag,
                  output deOut, bottomBin, topBin, weightTop, magBottom, magTop, angleFold);
endinterface

// File: rtl/hog_weight_split.sv
// Splits a magnitude between two bins by a fractional weight; one registered stage, frozen while ce is low.
module hog_weight_split #(
  parameter int MAG_W  = 12,
  parameter int FRAC_W = 8
) (
  input  logic              pclk,
  input  logic              resetN,
  input  logic              ce,
  input  logic [MAG_W-1:0]  mag,
  input  logic [FRAC_W-1:0] weight,
  output logic [MAG_W-1:0]  magTop,
  output logic [MAG_W-1:0]  magBottom
);
  localparam int PW = MAG_W + FRAC_W;

  logic [MAG_W-1:0] top_d, bot_d, top_q, bot_q;

  // Bottom share is the remainder, so the pair always sums exactly to mag.
  always_comb begin
    top_d = MAG_W'((PW'(mag) * PW'(weight)) >> FRAC_W);
    bot_d = mag - top_d;
  end

  always_ff @(posedge pclk or negedge resetN) begin
    if (!resetN) begin
      top_q <= '0;
      bot_q <= '0;
    end else if (ce) begin
      top_q <= top_d;
      bot_q <= bot_d;
    end
  end

  assign magTop    = top_q;
  assign magBottom = bot_q;
endmodule

// File: rtl/hog_bin_vote.sv
// Folds the gradient angle, picks the two neighbouring bins and splits the magnitude between them.
// Four ce-gated stages (fold, scale, bin select, split); ce low freezes everything including deOut.
module hog_bin_vote
  import hog_pkg::*;
#(
  parameter int ANGLE_W     = 12,
  parameter int ANGLE_FRAC  = 9,
  parameter int MAG_W       = 12,
  parameter int NUM_BINS    = 9,
  parameter int BIN_W       = 4,
  parameter int FRAC_W      = 8,
  parameter int FULL_CIRCLE = 0
) (
  input  logic          pclk,
  input  logic          resetN,
  input  logic          ce,
  hog_bin_vote_if.slave bus
);
  localparam int FW      = ANGLE_W - 1;
  localparam int R_I     = calc_range(ANGLE_FRAC, FULL_CIRCLE != 0);
  localparam int SC_I    = calc_scale(NUM_BINS, FULL_CIRCLE != 0);
  localparam int SCALE_W = $clog2(SC_I + 1);
  localparam int SHIFT   = ANGLE_FRAC + SCALE_FRAC;
  localparam int P_W     = FW + SCALE_W;
  localparam int IP_W    = P_W - SHIFT;
  localparam int KEEP_W  = IP_W + FRAC_W;

  localparam logic signed [ANGLE_W:0] R_S  = (ANGLE_W + 1)'(R_I);
  localparam logic [SCALE_W-1:0]      SC_C = SCALE_W'(SC_I);

  if (!params_ok(NUM_BINS, BIN_W)) begin : g_param_err
    $error("hog_bin_vote: NUM_BINS must be >= 2 and fit in BIN_W bits");
  end

  logic signed [ANGLE_W:0] f_sum;
  logic [FW-1:0]           f1_d, f1_q, f2_q, f3_q, f4_q;
  logic [MAG_W-1:0]        mag1_q, mag2_q, mag3_q;
  logic                    de1_q, de2_q, de3_q, de4_q;
  logic [KEEP_W-1:0]       p2_d, p2_q;
  logic [IP_W-1:0]         ip3;
  logic [BIN_W-1:0]        b3_d, t3_d, b3_q, t3_q, b4_q, t4_q;
  logic [FRAC_W-1:0]       w3_q, w4_q;

  // +pi and -pi both land on R and wrap to 0.
  always_comb begin
    f_sum = {bus.angle[ANGLE_W-1], bus.angle};
    if (f_sum < 0) f_sum = f_sum + R_S;
    if (f_sum >= R_S) f_sum = f_sum - R_S;
    f1_d = FW'(f_sum);
  end

  // Only the integer part and the top FRAC_W fraction bits of the product are kept.
  assign p2_d = KEEP_W'((P_W'(f1_q) * P_W'(SC_C)) >> (SHIFT - FRAC_W));
  assign ip3  = p2_q[KEEP_W-1:FRAC_W];

  always_comb begin
    b3_d = (32'(ip3) >= NUM_BINS) ? '0 : BIN_W'(ip3);
    t3_d = (b3_d == BIN_W'(NUM_BINS - 1)) ? '0 : b3_d + 1'b1;
  end

  always_ff @(posedge pclk or negedge resetN) begin
    if (!resetN) begin
      de1_q <= 1'b0;  f1_q <= '0;  mag1_q <= '0;
      de2_q <= 1'b0;  f2_q <= '0;  mag2_q <= '0;  p2_q <= '0;
      de3_q <= 1'b0;  f3_q <= '0;  mag3_q <= '0;  b3_q <= '0;  t3_q <= '0;  w3_q <= '0;
      de4_q <= 1'b0;  f4_q <= '0;  b4_q   <= '0;  t4_q <= '0;  w4_q <= '0;
    end else if (ce) begin
      de1_q <= bus.de;  f1_q <= f1_d;  mag1_q <= bus.mag;
      de2_q <= de1_q;   f2_q <= f1_q;  mag2_q <= mag1_q;  p2_q <= p2_d;
      de3_q <= de2_q;   f3_q <= f2_q;  mag3_q <= mag2_q;
      b3_q  <= b3_d;    t3_q <= t3_d;  w3_q   <= p2_q[FRAC_W-1:0];
      de4_q <= de3_q;   f4_q <= f3_q;  b4_q   <= b3_q;    t4_q <= t3_q;  w4_q <= w3_q;
    end
  end

  hog_weight_split #(
    .MAG_W  (MAG_W),
    .FRAC_W (FRAC_W)
  ) u_split (
    .pclk      (pclk),
    .resetN    (resetN),
    .ce        (ce),
    .mag       (mag3_q),
    .weight    (w3_q),
    .magTop    (bus.magTop),
    .magBottom (bus.magBottom)
  );

  assign bus.deOut     = de4_q;
  assign bus.bottomBin = b4_q;
  assign bus.topBin    = t4_q;
  assign bus.weightTop = w4_q;
  assign bus.angleFold = f4_q;
endmodule

// File: tb/tb_hog_bin_vote.sv
// Scoreboard bench for hog_bin_vote: default half-circle instance plus an 18-bin full-circle instance.
module tb_hog_bin_vote;

  typedef struct packed {
    logic        de;
    logic [3:0]  bb;
    logic [3:0]  tb;
    logic [7:0]  wt;
    logic [11:0] mb;
    logic [11:0] mt;
    logic [10:0] af;
  } out_t;

  typedef struct {
    int   due;
    int   mag;
    out_t exp;
  } sb_t;

  logic pclk = 1'b0;
  logic resetN = 1'b0;
  logic ce = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;
  sb_t  sb[$];

  hog_bin_vote_if #(.ANGLE_W(12), .MAG_W(12), .BIN_W(4), .FRAC_W(8)) bus ();
  hog_bin_vote_if #(.ANGLE_W(13), .MAG_W(12), .BIN_W(5), .FRAC_W(8)) bus_fc ();

  hog_bin_vote dut (.pclk(pclk), .resetN(resetN), .ce(ce), .bus(bus));

  hog_bin_vote #(
    .ANGLE_W(13), .NUM_BINS(18), .BIN_W(5), .FULL_CIRCLE(1)
  ) dut_fc (.pclk(pclk), .resetN(resetN), .ce(ce), .bus(bus_fc));

  always #5 pclk = ~pclk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Independent reference: R=1608, SCALE=11734, 21 fractional bits in the product.
  function automatic out_t model(input logic d, input int a, input int m);
    out_t   o;
    int     f, b, w, mt;
    longint p;
    f = a;
    if (f < 0) f = f + 1608;
    if (f >= 1608) f = f - 1608;
    p  = longint'(f) * 64'sd11734;
    b  = int'(p >>> 21);
    if (b >= 9) b = 0;
    w  = int'((p >>> 13) & 64'sd255);
    mt = (m * w) >>> 8;
    o.de = d;
    o.bb = 4'(b);
    o.tb = (b == 8) ? 4'd0 : 4'(b + 1);
    o.wt = 8'(w);
    o.mt = 12'(mt);
    o.mb = 12'(m - mt);
    o.af = 11'(f);
    return o;
  endfunction

  function automatic out_t obs();
    return {bus.deOut, bus.bottomBin, bus.topBin, bus.weightTop,
            bus.magBottom, bus.magTop, bus.angleFold};
  endfunction

  function automatic logic [54:0] obs_fc();
    return {bus_fc.deOut, bus_fc.bottomBin, bus_fc.topBin, bus_fc.weightTop,
            bus_fc.magBottom, bus_fc.magTop, bus_fc.angleFold};
  endfunction

  task automatic drive(input logic d, input int a, input int m, input logic c, input bit rec);
    @(negedge pclk);
    bus.de    = d;
    bus.angle = 12'(a);
    bus.mag   = 12'(m);
    ce        = c;
    if (rec && c && resetN) sb.push_back('{due: en_cnt + 4, mag: m, exp: model(d, a, m)});
    @(posedge pclk);
    #1;
    if (c && resetN) en_cnt++;
  endtask

  task automatic test_reset();
    out_t o;
    bus.de = 1'b0; bus.angle = '0; bus.mag = '0;
    bus_fc.de = 1'b0; bus_fc.angle = '0; bus_fc.mag = '0;
    repeat (3) @(posedge pclk);
    #1;
    o = obs();
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_main: got %h want 0", o); end
    checks++;
    if (obs_fc() !== '0) begin errors++; $display("FAIL reset_fc: got %h want 0", obs_fc()); end
    @(negedge pclk);
    resetN = 1'b1;
  endtask

  task automatic test_directed();
    int   ang[5]  = '{0, -804, 1607, 1608, -1608};
    int   mg[5]   = '{100, 200, 256, 50, 77};
    out_t tab[5]  = '{
      '{1'b1, 4'd0, 4'd1, 8'd0,   12'd100, 12'd0,   11'd0},
      '{1'b1, 4'd4, 4'd5, 8'd127, 12'd101, 12'd99,  11'd804},
      '{1'b1, 4'd8, 4'd0, 8'd253, 12'd3,   12'd253, 11'd1607},
      '{1'b1, 4'd0, 4'd1, 8'd0,   12'd50,  12'd0,   11'd0},
      '{1'b1, 4'd0, 4'd1, 8'd0,   12'd77,  12'd0,   11'd0}};
    sb_t  e;
    out_t o;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        sb.push_back('{due: en_cnt + 4, mag: mg[i], exp: tab[i]});
        drive(1'b1, ang[i], mg[i], 1'b1, 1'b0);
      end else begin
        drive(1'b0, 0, 0, 1'b1, 1'b0);
      end
      while (sb.size() > 0 && sb[0].due <= en_cnt) begin
        e = sb.pop_front();
        o = obs();
        checks++;
        if (o !== e.exp) begin errors++; $display("FAIL directed: got %h want %h", o, e.exp); end
      end
    end
  endtask

  task automatic test_full_circle();
    bus_fc.de = 1'b1; bus_fc.angle = -13'sd804; bus_fc.mag = 12'd200;
    drive(1'b0, 0, 0, 1'b1, 1'b0);
    bus_fc.de = 1'b0; bus_fc.angle = '0; bus_fc.mag = '0;
    repeat (3) drive(1'b0, 0, 0, 1'b1, 1'b0);
    checks++;
    if (bus_fc.deOut !== 1'b1) begin errors++; $display("FAIL fc_de: got %b want 1", bus_fc.deOut); end
    checks++;
    if (bus_fc.angleFold !== 12'd2413) begin errors++; $display("FAIL fc_fold: got %0d want 2413", bus_fc.angleFold); end
    checks++;
    if (bus_fc.bottomBin !== 5'd13) begin errors++; $display("FAIL fc_bottom: got %0d want 13", bus_fc.bottomBin); end
    checks++;
    if (bus_fc.topBin !== 5'd14) begin errors++; $display("FAIL fc_top: got %0d want 14", bus_fc.topBin); end
    checks++;
    if (bus_fc.weightTop !== 8'd128) begin errors++; $display("FAIL fc_weight: got %0d want 128", bus_fc.weightTop); end
    checks++;
    if (bus_fc.magTop !== 12'd100 || bus_fc.magBottom !== 12'd100) begin
      errors++;
      $display("FAIL fc_split: got top %0d bottom %0d want 100/100", bus_fc.magTop, bus_fc.magBottom);
    end
  endtask

  task automatic test_back_to_back();
    sb_t  e;
    out_t o;
    for (int i = 0; i < 45; i++) begin
      if (i < 40)
        drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 3216)) - 1608,
              int'($urandom_range(0, 4095)), 1'b1, 1'b1);
      else
        drive(1'b0, 0, 0, 1'b1, 1'b0);
      while (sb.size() > 0 && sb[0].due <= en_cnt) begin
        e = sb.pop_front();
        o = obs();
        checks++;
        if (o !== e.exp) begin errors++; $display("FAIL back_to_back: got %h want %h", o, e.exp); end
      end
    end
  endtask

  task automatic test_ce_stall();
    sb_t  e;
    out_t o, prev;
    logic c;
    for (int i = 0; i < 80; i++) begin
      c    = (i >= 70) ? 1'b1 : 1'($urandom_range(0, 1));
      prev = obs();
      if (i < 70)
        drive($urandom_range(0, 1) == 1, int'($urandom_range(0, 3216)) - 1608,
              int'($urandom_range(0, 4095)), c, 1'b1);
      else
        drive(1'b0, 0, 0, 1'b1, 1'b0);
      if (!c) begin
        checks++;
        if (obs() !== prev) begin errors++; $display("FAIL ce_hold: got %h want %h", obs(), prev); end
      end
      while (sb.size() > 0 && sb[0].due <= en_cnt) begin
        e = sb.pop_front();
        o = obs();
        checks++;
        if (o !== e.exp) begin errors++; $display("FAIL ce_stream: got %h want %h", o, e.exp); end
        if (o.de) begin
          checks++;
          if (13'(o.mb) + 13'(o.mt) !== 13'(e.mag)) begin
            errors++;
            $display("FAIL mag_sum: got %0d want %0d", 13'(o.mb) + 13'(o.mt), e.mag);
          end
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    sb_t  e;
    out_t o;
    for (int i = 0; i < 40; i++) begin
      if (i == 15) begin
        @(negedge pclk);
        #2;
        resetN = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (obs() !== '0) begin errors++; $display("FAIL reset_async: got %h want 0", obs()); end
        drive(1'b1, 700, 900, 1'b1, 1'b1);
        checks++;
        if (obs() !== '0 || obs_fc() !== '0) begin
          errors++;
          $display("FAIL reset_held: got %h / %h want 0", obs(), obs_fc());
        end
        @(negedge pclk);
        resetN = 1'b1;
      end
      if (i >= 15 && i < 20)
        drive(1'b0, 0, 0, 1'b1, 1'b1);
      else if (i < 35)
        drive($urandom_range(0, 9) < 6, int'($urandom_range(0, 3216)) - 1608,
              int'($urandom_range(0, 4095)), 1'($urandom_range(0, 3) != 0), 1'b1);
      else
        drive(1'b0, 0, 0, 1'b1, 1'b0);
      while (sb.size() > 0 && sb[0].due <= en_cnt) begin
        e = sb.pop_front();
        o = obs();
        checks++;
        if (o !== e.exp) begin errors++; $display("FAIL reset_stream: got %h want %h", o, e.exp); end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_full_circle();
    test_back_to_back();
    test_ce_stall();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hog_bin_vote.md
# hog_bin_vote

Parametrised orientation-binning stage for the HOG car-detection pipeline, placed between the gradient angle/magnitude unit and the cell histogram accumulator. Per pixel it folds the signed gradient angle into the selected orientation range, selects the two neighbouring histogram bins, and splits the gradient magnitude between them by linear interpolation. Bin count, angle width, weight precision and half/full-circle mode are generic. A clock enable allows stalls.

## Interface

**Parameters**
- ANGLE_W, 12: signed angle width, radians.
- ANGLE_FRAC, 9: fractional bits of the angle.
- MAG_W, 12: unsigned magnitude width.
- NUM_BINS, 9: number of histogram bins, 2..16.
- BIN_W, 4: bin index width; must satisfy 2^BIN_W ≥ NUM_BINS.
- FRAC_W, 8: interpolation weight width.
- FULL_CIRCLE, 0:
  - 0: fold to [0, π).
  - 1: fold to [0, 2π).

**Ports**
- pclk, in, 1: pixel clock.
- resetN, in, 1: asynchronous, active-low reset.
- ce, in, 1: clock enable. Low freezes every pipeline register.
- de, in, 1: input data valid.
- angle, in, ANGLE_W: signed, in [−π, π].
- mag, in, MAG_W: gradient magnitude.
- deOut, out, 1: output valid.
- bottomBin, out, BIN_W: lower bin index.
- topBin, out, BIN_W: upper bin index, wrapped.
- weightTop, out, FRAC_W: fractional position between bottomBin and topBin.
- magBottom, out, MAG_W: magnitude share for bottomBin.
- magTop, out, MAG_W: magnitude share for topBin.
- angleFold, out, ANGLE_W−1: folded angle, unsigned, with ANGLE_FRAC fractional bits.

## Operation

**Constants**
- R = round(π·2^ANGLE_FRAC), or round(2π·2^ANGLE_FRAC) when FULL_CIRCLE=1.
- SCALE = round(NUM_BINS/range · 2^12).
- Default R = 1608. For NUM_BINS=9 half-circle and NUM_BINS=18 full-circle, SCALE = 11734.

**Stage 1 (fold)**
- f = angle + R if angle < 0, else angle.
- If f ≥ R, f = f − R. This makes +π and −π both map to 0.

**Stage 2 (scale)**
- p = f · SCALE, unsigned, full product width.
- Integer part is p >> (ANGLE_FRAC+12).

**Stage 3 (bin select)**
- b = integer part of p.
- If b ≥ NUM_BINS, b = 0. This covers rounding at the top edge.
- weightTop = next FRAC_W bits below the binary point, truncated.
- topBin = (b == NUM_BINS−1) ? 0 : b+1.

**Stage 4 (split)**
- magTop = (mag · weightTop) >> FRAC_W, truncated.
- magBottom = mag − magTop. The two shares always sum exactly to mag.

**Sideband and validity**
- mag, de and f travel alongside in matching delay registers.
- Data outputs are computed regardless of de. Consumers qualify them with deOut.

## Timing

- Latency is exactly 4 enabled cycles from (de, angle, mag) to all outputs. Throughput is one pixel per enabled cycle.
- ce low: all stages and deOut hold their values. No pixel is dropped or duplicated.
- Reset asserted at any time asynchronously clears every output and every pipeline register to 0, including deOut. In-flight pixels are discarded.
- After reset release, deOut stays 0 for at least 4 enabled cycles unless de is driven.
- Back-to-back de with gaps are preserved bit-exactly in deOut, shifted by 4 enabled cycles.

## Structure

**Package hog_pkg**
- Constant functions computing R and SCALE from the parameters.
- Typedefs for the folded-angle and bin-index widths.
- Elaboration-time assertions on NUM_BINS and BIN_W.

**Sub-module hog_weight_split**
- Contains stage 4: the mag × weight multiply and subtract, with its own ce/resetN register.
- Reused later by the block-normalisation voting path.

All remaining stages stay in hog_bin_vote.

## Test plan

Defaults unless stated; all outputs sampled 4 cycles after input.

1. angle=0, mag=100 → bottomBin=0, topBin=1, weightTop=0, magBottom=100, magTop=0.
2. angle=−804 (−π/2), mag=200 → angleFold=804, bottomBin=4, topBin=5, weightTop=127, magTop=99, magBottom=101.
3. angle=1607, mag=256 → bottomBin=8, topBin=0 (wrap), weightTop=253, magTop=253, magBottom=3.
4. angle=+1608 then −1608 → both give angleFold=0 and bottomBin=0.
5. FULL_CIRCLE=1, NUM_BINS=18, BIN_W=5, angle=−804 → angleFold=2413, bottomBin=13, topBin=14, weightTop=128.
6. Random stream with ce toggled randomly and resetN pulsed mid-stream:
   - outputs match a reference model, with latency counted in enabled cycles;
   - all outputs are 0 while reset is asserted;
   - magBottom+magTop == mag on every valid pixel.
